// File: rtl/cuda_core_pipe.sv
// LANES-wide SIMD integer ALU: operand latch and ALU/result stages feed a show-ahead output
// FIFO. Issue is gated by credits so the pipeline never has to stall.
module cuda_core_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LANES*WIDTH-1:0]          I_dataA,
  input  logic [LANES*WIDTH-1:0]          I_dataB,
  input  logic [3:0]                      I_opcode,
  input  logic                            I_ctrl,
  output logic                            O_accept,
  output logic [LANES*WIDTH-1:0]          O_data,
  output logic                            O_illegal,
  output logic                            O_ctrl,
  input  logic                            I_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] O_count
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW  = LANES * WIDTH;

  function automatic logic [WIDTH-1:0] lane_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      4'd0:    lane_op = a + b;
      4'd1:    lane_op = a - b;
      4'd2:    lane_op = a & b;
      4'd3:    lane_op = a | b;
      4'd4:    lane_op = a ^ b;
      4'd5:    lane_op = a << sh;
      4'd6:    lane_op = a >> sh;
      4'd7:    lane_op = $signed(a) >>> sh;
      4'd8:    lane_op = WIDTH'($signed(a) < $signed(b));
      4'd9:    lane_op = WIDTH'(a < b);
      4'd10:   lane_op = a * b;
      4'd11:   lane_op = ($signed(a) < $signed(b)) ? a : b;
      4'd12:   lane_op = ($signed(a) > $signed(b)) ? a : b;
      default: lane_op = '0;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic          r_s1_valid;
  logic [DW-1:0] r_s1_a;
  logic [DW-1:0] r_s1_b;
  logic [3:0]    r_s1_op;
  logic          r_s2_valid;
  logic [DW-1:0] r_s2_data;
  logic          r_s2_ill;

  logic [DW-1:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_ill;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [DW-1:0] w_alu;
  logic          w_alu_ill;
  logic [CW:0]   w_inflight;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_alu[g*WIDTH +: WIDTH] =
        lane_op(r_s1_op, r_s1_a[g*WIDTH +: WIDTH], r_s1_b[g*WIDTH +: WIDTH]);
  end
  assign w_alu_ill = (r_s1_op > 4'd12);

  // Every result already in flight owns a FIFO slot, so s1/s2 can advance unconditionally.
  assign w_inflight = {1'b0, r_count} + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
  assign O_accept   = (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_issue    = I_ctrl & O_accept;
  assign w_push     = r_s2_valid;
  assign w_pop      = O_ctrl & I_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_s2_valid <= r_s1_valid;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_s1_a  <= I_dataA;
      r_s1_b  <= I_dataB;
      r_s1_op <= I_opcode;
    end
    r_s2_data <= w_alu;
    r_s2_ill  <= w_alu_ill;
    if (w_push) begin
      r_mem[r_wr_ptr]     <= r_s2_data;
      r_mem_ill[r_wr_ptr] <= r_s2_ill;
    end
  end

  assign O_ctrl    = (r_count != '0);
  assign O_data    = O_ctrl ? r_mem[r_rd_ptr] : '0;
  assign O_illegal = O_ctrl & r_mem_ill[r_rd_ptr];
  assign O_count   = r_count;

endmodule

// File: tb/tb_cuda_core_pipe.sv
// Bench for cuda_core_pipe: an in-order result queue with ready-times models the core, and
// directed tests pin specific results, latency, backpressure and reset behaviour.
module tb_cuda_core_pipe;
  localparam int W = 32;
  localparam int L = 4;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [L*W-1:0]   I_dataA, I_dataB;
  logic [3:0]       I_opcode;
  logic             I_ctrl;
  logic             O_accept;
  logic [L*W-1:0]   O_data;
  logic             O_illegal;
  logic             O_ctrl;
  logic             I_ready;
  logic [2:0]       O_count;

  cuda_core_pipe #(.WIDTH(W), .LANES(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .I_dataA(I_dataA), .I_dataB(I_dataB), .I_opcode(I_opcode),
    .I_ctrl(I_ctrl), .O_accept(O_accept), .O_data(O_data), .O_illegal(O_illegal),
    .O_ctrl(O_ctrl), .I_ready(I_ready), .O_count(O_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference semantics of one lane, from the opcode table.
  function automatic logic [W-1:0] ref_lane(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int sa, sb, s;
    longint unsigned p;
    logic [W-1:0] ones;
    sa = $signed(a);
    sb = $signed(b);
    s = int'(b % 32);
    ones = '1;
    p = a;
    p = p * b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << s;
      4'd6:  return a >> s;
      4'd7:  return (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
      4'd8:  return (sa < sb) ? 1 : 0;
      4'd9:  return (a < b) ? 1 : 0;
      4'd10: return p[W-1:0];
      4'd11: return (sa < sb) ? a : b;
      4'd12: return (sa > sb) ? a : b;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    logic [L*W-1:0] d;
    logic           ill;
    int             rdy;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  bit   chk_en = 0;

  // Model: every accepted issue owns one slot until popped; it becomes visible 2 edges later.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      chk_en = 1;
    end else begin
      bit acc;
      acc = (q.size() < D);
      if (q.size() > 0 && q[0].rdy < cyc && I_ready) void'(q.pop_front());
      if (I_ctrl && acc) begin
        ent_t e;
        for (int i = 0; i < L; i++)
          e.d[i*W +: W] = ref_lane(I_opcode, I_dataA[i*W +: W], I_dataB[i*W +: W]);
        e.ill = (I_opcode >= 4'd13);
        e.rdy = cyc + 2;
        q.push_back(e);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int c;
      bit vis;
      c = 0;
      foreach (q[i]) if (q[i].rdy < cyc) c++;
      vis = (c > 0);
      chk("accept", O_accept, q.size() < D);
      chk("ctrl", O_ctrl, vis);
      chk("count", O_count, c);
      chk("occupancy", O_count <= D, 1);
      if (vis) begin
        chk("head data", O_data, q[0].d);
        chk("head illegal", O_illegal, q[0].ill);
      end else begin
        chk("idle data", O_data, 0);
        chk("idle illegal", O_illegal, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    int n;
    n = 0;
    I_opcode = op;
    I_dataA = a;
    I_dataB = b;
    I_ctrl = 1'b1;
    while (!O_accept && n < 20) begin
      tick();
      n++;
    end
    chk("issue accept", O_accept, 1);
    tick();
    I_ctrl = 1'b0;
  endtask

  task automatic wait_head(input string name, input logic [L*W-1:0] exp_d, input logic exp_ill);
    int n;
    n = 0;
    while (!O_ctrl && n < 20) begin
      tick();
      n++;
    end
    chk({name, " valid"}, O_ctrl, 1);
    chk({name, " data"}, O_data, exp_d);
    chk({name, " illegal"}, O_illegal, exp_ill);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acc;
    logic [L*W-1:0] held;
    rst = 1'b1;
    I_ctrl = 1'b0;
    I_ready = 1'b1;
    I_opcode = '0;
    I_dataA = '0;
    I_dataB = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset ctrl", O_ctrl, 0);
    chk("reset count", O_count, 0);
    chk("reset accept", O_accept, 1);
    chk("reset data", O_data, 0);
    chk("reset illegal", O_illegal, 0);

    // Single ADD with wraparound on lane 0; check 2-cycle latency.
    issue(4'd0, {32'h0, 32'h0, 32'd7, 32'hFFFF_FFFF}, {32'h0, 32'h0, 32'd5, 32'h1});
    lat = 0;
    while (!O_ctrl && lat < 10) begin
      tick();
      lat++;
    end
    chk("add latency", lat, 2);
    chk("add data", O_data, {32'h0, 32'h0, 32'hC, 32'h0});
    chk("add illegal", O_illegal, 0);
    tick();

    issue(4'd7, {96'h0, 32'h8000_0000}, {96'h0, 32'd4});
    wait_head("sra", {96'h0, 32'hF800_0000}, 1'b0);
    issue(4'd8, {96'h0, 32'hFFFF_FFFF}, {96'h0, 32'd1});
    wait_head("slt", {96'h0, 32'd1}, 1'b0);
    issue(4'd9, {96'h0, 32'hFFFF_FFFF}, {96'h0, 32'd1});
    wait_head("sltu", {96'h0, 32'd0}, 1'b0);
    issue(4'd10, {96'h0, 32'h0001_0000}, {96'h0, 32'h0001_0000});
    wait_head("mul", {96'h0, 32'd0}, 1'b0);
    issue(4'd11, {96'h0, 32'hFFFF_FFFD}, {96'h0, 32'd2});
    wait_head("min", {96'h0, 32'hFFFF_FFFD}, 1'b0);
    issue(4'd14, {96'h0, 32'h1234}, {96'h0, 32'h5678});
    wait_head("undef", 128'h0, 1'b1);
    issue(4'd0, {96'h0, 32'd2}, {96'h0, 32'd2});
    wait_head("add after undef", {96'h0, 32'd4}, 1'b0);

    // Backpressure: fill the credit window with the sink stalled.
    I_ready = 1'b0;
    I_ctrl = 1'b1;
    I_opcode = 4'd0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      I_dataA = 128'(i + 100);
      I_dataB = 128'(1);
      if (O_accept) acc++;
      tick();
    end
    I_ctrl = 1'b0;
    chk("bp accepts", acc, 4);
    chk("bp accept low", O_accept, 0);
    chk("bp count", O_count, 4);
    held = O_data;
    repeat (3) tick();
    chk("bp stable", O_data, held);
    chk("bp head", O_data, 128'd101);
    I_ready = 1'b1;
    for (int k = 0; k < 4; k++) wait_head("bp drain", 128'(101 + k), 1'b0);
    chk("bp empty", O_count, 0);

    // Streaming: back-to-back random issues with the sink always ready.
    I_ctrl = 1'b1;
    for (int i = 0; i < 100; i++) begin
      I_opcode = 4'($urandom_range(0, 15));
      I_dataA = {$urandom(), $urandom(), $urandom(), $urandom()};
      I_dataB = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk("stream accept", O_accept, 1);
      tick();
    end
    I_ctrl = 1'b0;
    repeat (6) tick();
    chk("stream drained", O_count, 0);

    // Mid-flight reset: three issues, then reset with a fourth issue presented.
    I_ready = 1'b0;
    I_ctrl = 1'b1;
    I_opcode = 4'd0;
    for (int i = 0; i < 3; i++) begin
      I_dataA = 128'(i + 1);
      I_dataB = 128'(i + 1);
      tick();
    end
    rst = 1'b1;
    I_dataA = 128'(55);
    tick();
    rst = 1'b0;
    I_ctrl = 1'b0;
    I_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post reset ctrl", O_ctrl, 0);
      chk("post reset count", O_count, 0);
      tick();
    end
    issue(4'd4, {96'h0, 32'hF0}, {96'h0, 32'hFF});
    wait_head("xor after reset", {96'h0, 32'h0F}, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cuda_core_pipe.md
Name: cuda_core_pipe

Overview:
- Parametrised successor to the single-lane integer CUDA core.
- LANES-wide SIMD integer datapath: all lanes share one opcode and are issued together per transaction.
- Two-stage registered pipeline (operand latch, ALU/result) feeds an output FIFO.
- Credit-based backpressure toward the issue side; valid/ready toward the writeback side.

Parameters:
WIDTH, 32, bits per lane operand/result
LANES, 4, number of parallel ALU lanes
FIFO_DEPTH, 4, output FIFO entries; legal range 2..64; full throughput requires >=4

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
I_dataA  in  LANES*WIDTH  operand A; lane i = bits [i*WIDTH +: WIDTH]
I_dataB  in  LANES*WIDTH  operand B, same packing
I_opcode  in  4  operation shared by all lanes
I_ctrl  in  1  issue valid
O_accept  out  1  core can take an issue this cycle
O_data  out  LANES*WIDTH  result at FIFO head
O_illegal  out  1  head entry was issued with an undefined opcode
O_ctrl  out  1  O_data/O_illegal valid
I_ready  in  1  downstream takes head this cycle
O_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset: rst sampled high at an edge clears the s1/s2 valid bits, FIFO pointers and count. After that edge, O_ctrl=0, O_count=0, O_accept=1 and O_illegal=0. O_data is 0 while O_ctrl=0.
- Reset mid-operation: all in-flight and buffered results are discarded, with no partial output. Issues presented in the reset cycle are ignored.
- Issue handshake: an issue is accepted at an edge where I_ctrl & O_accept. I_ctrl without O_accept is a no-op; the core does not latch the data.
- Credit rule: O_accept = (O_count + s1_valid + s2_valid) < FIFO_DEPTH.
  - Combinational from registered state only.
  - Does not credit a same-cycle pop, so it is conservative.
  - Never depends on I_ctrl or I_ready.
- Pipeline:
  - Edge N (accept): operands and opcode are captured into s1.
  - Edge N+1: lane results are computed from s1 and registered into s2.
  - Edge N+2: s2 is written into the FIFO.
  - s1/s2 always advance; they never stall, because credit guarantees FIFO space.
- Latency: if the FIFO is empty, O_ctrl rises in the cycle after edge N+2, i.e. 2 cycles from accept. Results leave in issue order.
- FIFO is show-ahead: O_data, O_illegal and O_ctrl reflect the head combinationally from the registers.
  - Pop occurs at an edge where O_ctrl & I_ready.
  - O_data stays stable while O_ctrl & !I_ready.
  - Simultaneous push and pop: count is unchanged and pointers both advance.
  - A push into an empty FIFO is not visible until the cycle after the edge.
  - Pointers wrap modulo FIFO_DEPTH, so non-power-of-2 depths are legal.
- Per-lane opcodes (a, b are WIDTH-bit):
  - 0 ADD, 1 SUB: modulo 2^WIDTH; carry and overflow are dropped.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = b[$clog2(WIDTH)-1:0].
  - 8 SLT (signed), 9 SLTU: result 1 or 0, zero-extended.
  - 10 MUL: low WIDTH bits of the product.
  - 11 MIN, 12 MAX: signed.
  - 13-15: undefined. Lane results are 0 and the entry's illegal bit is 1. The core does not lock up, and later entries are unaffected.
- Throughput: one issue per cycle sustained when FIFO_DEPTH>=4 and I_ready is held high. At the credit limit, O_accept drops until pops free space.
- Invariant: O_count + s1_valid + s2_valid <= FIFO_DEPTH at all times. The bench checks this every cycle.

Test Plan:
- Reset check: rst=1 for 2 cycles, then idle -> O_ctrl=0, O_count=0, O_accept=1, O_data=0.
- Single ADD: lane0 A=0xFFFFFFFF, B=0x1; lane1 A=7, B=5; issue at edge N with I_ready=1 -> O_ctrl=1 in the cycle after edge N+2; lane0=0x0, lane1=0xC; O_illegal=0.
- Opcode sweep, one lane at a time:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
  - MUL 0x10000 * 0x10000 -> 0x0.
  - MIN -3 vs 2 -> 0xFFFFFFFD.
  - opcode 14 -> data 0 with O_illegal=1; the next ADD 2+2 returns 4 with O_illegal=0.
- Backpressure: I_ready=0, I_ctrl=1 continuously, FIFO_DEPTH=4 -> exactly 4 accepts, then O_accept=0 with O_count=4. Raising I_ready drains results in issue order, and O_data stays stable while stalled.
- Streaming: I_ready=1, 100 back-to-back random issues -> O_accept stays 1 throughout, 100 in-order results match the reference model, and the occupancy invariant holds every cycle.
- Mid-flight reset: issue 3 ops, assert rst at edge N+1 -> O_ctrl=0 next cycle; no stale result ever appears; a fresh XOR 0xF0 ^ 0xFF returns 0x0F.
